// File: rtl/scurve_scan_ctrl.sv
// rtl/scurve_scan_ctrl.sv - S-curve DAC/channel scan sequencer feeding the USB data FIFO
// Optional feature macro SCURVE_CHECKSUM_EN: emit a 16-bit running sum word ahead of the trailer.
module scurve_scan_ctrl #(
   parameter int                 CHN_NUM         = 64,
   parameter int                 DAC_WIDTH       = 10,
   parameter bit                 DAC_BIT_REVERSE = 1'b1,
   parameter logic [CHN_NUM-1:0] CTEST_ALL       = '0,
   localparam int                CHN_W           = $clog2(CHN_NUM)
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic                 Test_Start,
   input  logic                 Test_Abort,
   input  logic                 Single_or_Multi,
   input  logic [CHN_W-1:0]     Single_Chn,
   input  logic [DAC_WIDTH-1:0] Dac_Start,
   input  logic [DAC_WIDTH-1:0] Dac_Stop,
   input  logic [DAC_WIDTH-1:0] Dac_Step,
   output logic                 Single_Test_Start,
   input  logic                 Single_Test_Done,
   input  logic                 SCurve_Data_fifo_empty,
   input  logic [15:0]          SCurve_Data_fifo_dout,
   output logic                 SCurve_Data_fifo_rd_en,
   output logic [CHN_NUM-1:0]   CTest_Chn_Out,
   output logic [DAC_WIDTH-1:0] Dac_Out,
   output logic                 SC_Param_Load,
   input  logic                 SC_Config_Done,
   output logic [15:0]          usb_data_fifo_wr_din,
   output logic                 usb_data_fifo_wr_en,
   input  logic                 usb_data_fifo_full,
   output logic                 Test_Busy,
   output logic                 SCurve_Test_Done
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_CHN_WR, S_DAC_WR, S_SC_LOAD, S_SC_WAIT, S_PT_START, S_PT_WAIT,
      S_DRAIN_CHK, S_DRAIN_RD, S_DRAIN_WR, S_NEXT_DAC, S_NEXT_CHN, S_SUM, S_TRAIL, S_DONE
   } state_t;

`ifdef SCURVE_CHECKSUM_EN
   localparam state_t END_ST = S_SUM;
`else
   localparam state_t END_ST = S_TRAIL;
`endif

   state_t               state_q, state_d, wr_next;
   logic                 single_q, single_d, abort_q, abort_d, done_q, done_d, start_prev_q;
   logic [CHN_W-1:0]     chan_q, chan_d;
   logic [CHN_NUM-1:0]   mask_q, mask_d;
   logic [DAC_WIDTH-1:0] dac_q, dac_d, start_q, start_d, stop_q, stop_d, step_q, step_d;
   logic [DAC_WIDTH-1:0] dac_rev;
   logic [DAC_WIDTH:0]   dac_nxt;
   logic [15:0]          data_q, data_d, din_q, din_d, wr_word;
   logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d, sc_load_q, sc_load_d;
   logic                 pt_start_q, pt_start_d;
   logic                 wr_req, wr_abortable, abort_now, dac_last, start_rise;

   assign start_rise = Test_Start & ~start_prev_q;
   assign abort_now  = Test_Abort | abort_q;
   assign dac_nxt    = {1'b0, dac_q} + {1'b0, step_q};
   assign dac_last   = dac_nxt[DAC_WIDTH] || (dac_nxt > {1'b0, stop_q});

`ifdef SCURVE_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   always_comb begin
      sum_d = sum_q;
      if (state_q == S_IDLE && start_rise)
         sum_d = '0;
      else if (wr_en_d && (state_q inside {S_CHN_WR, S_DAC_WR, S_DRAIN_WR}))
         sum_d = sum_q + din_d;
   end
`endif

   always_comb begin
      state_d = state_q;  single_d = single_q; chan_d = chan_q;   mask_d = mask_q;
      dac_d   = dac_q;    start_d  = start_q;  stop_d = stop_q;   step_d = step_q;
      data_d  = data_q;   abort_d  = abort_q;  done_d = done_q;   din_d  = din_q;
      wr_en_d = 1'b0;     rd_en_d  = 1'b0;     sc_load_d = 1'b0;  pt_start_d = 1'b0;
      wr_req  = 1'b0;     wr_word  = din_q;    wr_next = state_q; wr_abortable = 1'b1;
      if (!(state_q inside {S_IDLE, S_TRAIL, S_DONE, S_SUM}))
         abort_d = abort_now;
      case (state_q)
         S_IDLE: if (start_rise) begin
            single_d = Single_or_Multi;
            chan_d   = Single_or_Multi ? Single_Chn : '0;
            mask_d   = Single_or_Multi ? CTEST_ALL : CHN_NUM'(1);
            dac_d    = Dac_Start;
            start_d  = Dac_Start;
            stop_d   = Dac_Stop;
            step_d   = (Dac_Step == '0) ? DAC_WIDTH'(1) : Dac_Step;
            abort_d  = 1'b0;
            done_d   = 1'b0;
            state_d  = S_HDR;
         end
         S_HDR:      begin wr_req = 1'b1; wr_word = 16'h5343; wr_next = S_CHN_WR; end
         S_CHN_WR:   begin
            wr_req = 1'b1; wr_word = {single_q ? 8'h63 : 8'h43, 8'(chan_q)}; wr_next = S_DAC_WR;
         end
         S_DAC_WR:   begin wr_req = 1'b1; wr_word = {4'hD, 12'(dac_q)}; wr_next = S_SC_LOAD; end
         S_SC_LOAD:  if (abort_now) state_d = END_ST;
                     else begin sc_load_d = 1'b1; state_d = S_SC_WAIT; end
         S_SC_WAIT:  if (abort_now) state_d = END_ST;
                     else if (SC_Config_Done) state_d = S_PT_START;
         S_PT_START: if (abort_now) state_d = END_ST;
                     else begin pt_start_d = 1'b1; state_d = S_PT_WAIT; end
         S_PT_WAIT:  if (abort_now) state_d = END_ST;
                     else if (Single_Test_Done) state_d = S_DRAIN_CHK;
         S_DRAIN_CHK: if (abort_now) state_d = END_ST;
                     else if (!SCurve_Data_fifo_empty) begin rd_en_d = 1'b1; state_d = S_DRAIN_RD; end
                     else state_d = S_NEXT_DAC;
         // First cycle carries the read strobe; dout is valid on the second.
         S_DRAIN_RD: if (!rd_en_q) begin data_d = SCurve_Data_fifo_dout; state_d = S_DRAIN_WR; end
         S_DRAIN_WR: begin wr_req = 1'b1; wr_word = data_q; wr_next = S_DRAIN_CHK; end
         S_NEXT_DAC: if (abort_now) state_d = END_ST;
                     else if (dac_last) state_d = S_NEXT_CHN;
                     else begin dac_d = dac_nxt[DAC_WIDTH-1:0]; state_d = S_DAC_WR; end
         S_NEXT_CHN: if (abort_now || single_q || chan_q == CHN_W'(CHN_NUM - 1)) state_d = END_ST;
                     else begin
                        chan_d  = chan_q + CHN_W'(1);
                        mask_d  = mask_q << 1;
                        dac_d   = start_q;
                        state_d = S_CHN_WR;
                     end
`ifdef SCURVE_CHECKSUM_EN
         S_SUM:      begin wr_req = 1'b1; wr_word = sum_q; wr_next = S_TRAIL; wr_abortable = 1'b0; end
`endif
         S_TRAIL:    begin
            wr_req = 1'b1; wr_word = abort_q ? 16'hFF41 : 16'hFF45;
            wr_next = S_DONE; wr_abortable = 1'b0;
         end
         S_DONE:     begin done_d = 1'b1; state_d = S_IDLE; end
         default:    state_d = S_IDLE;
      endcase
      if (wr_req && !usb_data_fifo_full) begin
         wr_en_d = 1'b1;
         din_d   = wr_word;
         state_d = (wr_abortable && abort_now) ? END_ST : wr_next;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= S_IDLE; single_q <= 1'b0; chan_q <= '0; mask_q <= '0; dac_q <= '0;
         start_q <= '0; stop_q <= '0; step_q <= '0; data_q <= '0; abort_q <= 1'b0;
         done_q <= 1'b0; din_q <= '0; wr_en_q <= 1'b0; rd_en_q <= 1'b0; sc_load_q <= 1'b0;
         pt_start_q <= 1'b0; start_prev_q <= 1'b0;
`ifdef SCURVE_CHECKSUM_EN
         sum_q <= '0;
`endif
      end else begin
         state_q <= state_d; single_q <= single_d; chan_q <= chan_d; mask_q <= mask_d;
         dac_q <= dac_d; start_q <= start_d; stop_q <= stop_d; step_q <= step_d;
         data_q <= data_d; abort_q <= abort_d; done_q <= done_d; din_q <= din_d;
         wr_en_q <= wr_en_d; rd_en_q <= rd_en_d; sc_load_q <= sc_load_d;
         pt_start_q <= pt_start_d; start_prev_q <= Test_Start;
`ifdef SCURVE_CHECKSUM_EN
         sum_q <= sum_d;
`endif
      end
   end

   always_comb begin
      dac_rev = '0;
      for (int i = 0; i < DAC_WIDTH; i++) dac_rev[i] = dac_q[DAC_WIDTH-1-i];
   end

   assign Dac_Out                = DAC_BIT_REVERSE ? dac_rev : dac_q;
   assign CTest_Chn_Out          = mask_q;
   assign Single_Test_Start      = pt_start_q;
   assign SCurve_Data_fifo_rd_en = rd_en_q;
   assign SC_Param_Load          = sc_load_q;
   assign usb_data_fifo_wr_din   = din_q;
   assign usb_data_fifo_wr_en    = wr_en_q;
   assign Test_Busy              = (state_q != S_IDLE);
   assign SCurve_Test_Done       = done_q;

endmodule

// File: tb/tb_scurve_scan_ctrl.sv
// tb/tb_scurve_scan_ctrl.sv - self-checking bench for scurve_scan_ctrl with SC/tester/FIFO models
module tb_scurve_scan_ctrl;
   localparam int CHN_NUM = 8;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       Test_Start = 1'b0, Test_Abort = 1'b0, Single_or_Multi = 1'b0;
   logic [2:0] Single_Chn = '0;
   logic [9:0] Dac_Start = '0, Dac_Stop = '0, Dac_Step = '0;
   logic       Single_Test_Start, Single_Test_Done, SCurve_Data_fifo_empty, SCurve_Data_fifo_rd_en;
   logic [15:0] SCurve_Data_fifo_dout, usb_data_fifo_wr_din;
   logic [7:0] CTest_Chn_Out;
   logic [9:0] Dac_Out;
   logic       SC_Param_Load, SC_Config_Done, usb_data_fifo_wr_en, usb_data_fifo_full;
   logic       Test_Busy, SCurve_Test_Done;

   scurve_scan_ctrl #(.CHN_NUM(CHN_NUM), .DAC_WIDTH(10), .DAC_BIT_REVERSE(1'b1), .CTEST_ALL(8'h00)) dut (
      .Clk(Clk), .reset(reset), .Test_Start(Test_Start), .Test_Abort(Test_Abort),
      .Single_or_Multi(Single_or_Multi), .Single_Chn(Single_Chn), .Dac_Start(Dac_Start),
      .Dac_Stop(Dac_Stop), .Dac_Step(Dac_Step), .Single_Test_Start(Single_Test_Start),
      .Single_Test_Done(Single_Test_Done), .SCurve_Data_fifo_empty(SCurve_Data_fifo_empty),
      .SCurve_Data_fifo_dout(SCurve_Data_fifo_dout), .SCurve_Data_fifo_rd_en(SCurve_Data_fifo_rd_en),
      .CTest_Chn_Out(CTest_Chn_Out), .Dac_Out(Dac_Out), .SC_Param_Load(SC_Param_Load),
      .SC_Config_Done(SC_Config_Done), .usb_data_fifo_wr_din(usb_data_fifo_wr_din),
      .usb_data_fifo_wr_en(usb_data_fifo_wr_en), .usb_data_fifo_full(usb_data_fifo_full),
      .Test_Busy(Test_Busy), .SCurve_Test_Done(SCurve_Test_Done));

   always #5 Clk = ~Clk;

   int checks = 0, failures = 0;
   logic [15:0] got[$], dfifo[$], trig_w[$], exp_w[$];
   logic [9:0]  ld_dac[$], exp_dac[$];
   logic [7:0]  ld_mask[$], exp_mask[$];
   int cnt_q[$];
   int pt_starts, full_viol, rd_under, sc_cnt, pt_cnt, cyc = 0, full_until = 0, wpp = 2;
   int clr_seq = 0, clr_seen = 0, rn;
   bit full_rand = 1'b0, rd_pend_v, full_s;
   logic [15:0] rd_pend, rw;
   int r_sm, r_ch, r_st, r_sp, r_stp, n0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] bitrev(input logic [9:0] d);
      for (int i = 0; i < 10; i++) bitrev[i] = d[9-i];
   endfunction

   always @(posedge Clk) full_s <= usb_data_fifo_full;

   // Environment: USB sink, data FIFO, SC loader and single-point tester models.
   always @(negedge Clk) begin
      cyc++;
      if (clr_seq != clr_seen) begin
         clr_seen = clr_seq;
         got.delete(); dfifo.delete(); trig_w.delete(); ld_dac.delete(); ld_mask.delete();
         cnt_q.delete(); pt_starts = 0; full_viol = 0; rd_under = 0; sc_cnt = 0; pt_cnt = 0;
         rd_pend_v = 1'b0;
      end
      if (usb_data_fifo_wr_en) begin
         if (full_s) full_viol++;
         got.push_back(usb_data_fifo_wr_din);
      end
      if (rd_pend_v) begin SCurve_Data_fifo_dout = rd_pend; rd_pend_v = 1'b0; end
      else SCurve_Data_fifo_dout = 16'hDEAD;
      if (SCurve_Data_fifo_rd_en) begin
         if (dfifo.size() == 0) rd_under++;
         else begin rd_pend = dfifo.pop_front(); rd_pend_v = 1'b1; end
      end
      SC_Config_Done = 1'b0;
      if (sc_cnt > 0) begin sc_cnt--; if (sc_cnt == 0) SC_Config_Done = 1'b1; end
      if (SC_Param_Load) begin
         ld_dac.push_back(Dac_Out); ld_mask.push_back(CTest_Chn_Out); sc_cnt = $urandom_range(1, 4);
      end
      Single_Test_Done = 1'b0;
      if (pt_cnt > 0) begin
         pt_cnt--;
         if (pt_cnt == 0) begin
            rn = (wpp < 0) ? $urandom_range(0, 3) : wpp;
            cnt_q.push_back(rn);
            for (int k = 0; k < rn; k++) begin
               rw = 16'($urandom); dfifo.push_back(rw); trig_w.push_back(rw);
            end
            Single_Test_Done = 1'b1;
         end
      end
      if (Single_Test_Start) begin pt_starts++; pt_cnt = $urandom_range(3, 6); end
      SCurve_Data_fifo_empty = (dfifo.size() == 0);
      usb_data_fifo_full = (cyc < full_until) || (full_rand && ($urandom_range(0, 2) == 0));
   end

   // Reference stream built from the scan rules: header, per-channel tag, per-point D word
   // plus the trigger words the tester produced, optional sum, trailer.
   task automatic build_expected(input bit sm, input int chn, input int st, input int sp,
                                 input int stp, input int abort_at);
      int stp_e, d, pt, ci, wi, n, ch;
      bit ab;
      logic [15:0] w, sum;
      exp_w.delete(); exp_dac.delete(); exp_mask.delete();
      exp_w.push_back(16'h5343);
      sum = '0; pt = 0; ci = 0; wi = 0; ab = 1'b0;
      stp_e = (stp == 0) ? 1 : stp;
      for (int c = 0; c < (sm ? 1 : CHN_NUM) && !ab; c++) begin
         ch = sm ? chn : c;
         w = {sm ? 8'h63 : 8'h43, 8'(ch)}; exp_w.push_back(w); sum += w;
         d = st;
         forever begin
            w = 16'hD000 | 16'(d); exp_w.push_back(w); sum += w;
            exp_dac.push_back(bitrev(10'(d)));
            exp_mask.push_back(sm ? 8'h00 : 8'(1 << ch));
            if (pt == abort_at) begin ab = 1'b1; break; end
            n = (ci < cnt_q.size()) ? cnt_q[ci] : 0; ci++;
            for (int k = 0; k < n; k++) begin
               w = (wi < trig_w.size()) ? trig_w[wi] : 16'h0; wi++;
               exp_w.push_back(w); sum += w;
            end
            pt++;
            if (d + stp_e > sp || d + stp_e > 1023) break;
            d += stp_e;
         end
      end
`ifdef SCURVE_CHECKSUM_EN
      exp_w.push_back(sum);
`endif
      exp_w.push_back(ab ? 16'hFF41 : 16'hFF45);
   endtask

   task automatic compare_all();
      chk("stream_len", got.size(), exp_w.size());
      for (int i = 0; i < got.size() && i < exp_w.size(); i++)
         chk($sformatf("stream[%0d]", i), got[i], exp_w[i]);
      chk("load_count", ld_dac.size(), exp_dac.size());
      for (int i = 0; i < ld_dac.size() && i < exp_dac.size(); i++) begin
         chk($sformatf("dac_out[%0d]", i), ld_dac[i], exp_dac[i]);
         chk($sformatf("ctest_mask[%0d]", i), ld_mask[i], exp_mask[i]);
      end
      chk("wr_while_full", full_viol, 0);
      chk("rd_underflow", rd_under, 0);
   endtask

   task automatic run_scan(input bit sm, input int chn, input int st, input int sp,
                           input int stp, input int abort_at, input int full_at);
      bit to;
      clr_seq++;
      repeat (2) @(negedge Clk);
      Single_or_Multi = sm; Single_Chn = 3'(chn);
      Dac_Start = 10'(st); Dac_Stop = 10'(sp); Dac_Step = 10'(stp);
      Test_Start = 1'b1;
      @(negedge Clk);
      chk("busy_after_start", Test_Busy, 1);
      chk("done_cleared", SCurve_Test_Done, 0);
      Single_or_Multi = ~sm; Single_Chn = 3'(chn + 3);
      Dac_Start = 10'($urandom); Dac_Stop = 10'($urandom); Dac_Step = 10'($urandom);
      if (full_at > 0) begin
         to = 1'b1;
         for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (got.size() >= full_at) begin to = 1'b0; break; end
         end
         chk("full_point_reached", to, 0);
         n0 = got.size();
         full_until = cyc + 20;
         repeat (20) @(negedge Clk);
         chk("no_write_while_full", got.size() <= n0 + 1, 1);
      end
      if (abort_at >= 0) begin
         to = 1'b1;
         for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (pt_starts == abort_at + 1) begin to = 1'b0; break; end
         end
         chk("abort_point_reached", to, 0);
         Test_Abort = 1'b1;
         repeat (2) @(negedge Clk);
         Test_Abort = 1'b0;
      end
      to = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge Clk);
         if (SCurve_Test_Done) begin to = 1'b0; break; end
      end
      chk("scan_done_seen", to, 0);
      chk("busy_low_at_done", Test_Busy, 0);
      repeat (6) @(negedge Clk);
      chk("held_start_no_restart", Test_Busy, 0);
      chk("done_level_held", SCurve_Test_Done, 1);
      Test_Start = 1'b0;
      build_expected(sm, chn, st, sp, stp, abort_at);
      compare_all();
   endtask

   initial begin
      repeat (4) @(negedge Clk);
      chk("rst_busy", Test_Busy, 0);
      chk("rst_done", SCurve_Test_Done, 0);
      chk("rst_wr_en", usb_data_fifo_wr_en, 0);
      chk("rst_din", usb_data_fifo_wr_din, 0);
      chk("rst_rd_en", SCurve_Data_fifo_rd_en, 0);
      chk("rst_sc_load", SC_Param_Load, 0);
      chk("rst_pt_start", Single_Test_Start, 0);
      chk("rst_dac", Dac_Out, 0);
      chk("rst_mask", CTest_Chn_Out, 0);
      reset = 1'b0;
      @(negedge Clk);

      wpp = 2;  run_scan(1'b1, 5, 0, 3, 1, -1, 0);
      wpp = -1; run_scan(1'b0, 0, 10, 10, 1, -1, 0);
      run_scan(1'b1, 0, 1000, 1023, 10, -1, 0);
      wpp = 3;  run_scan(1'b1, 2, 0, 3, 1, -1, 6);
      wpp = -1; run_scan(1'b0, 0, 10, 10, 1, 2, 0);
      run_scan(1'b1, 7, 7, 3, 0, -1, 0);
      run_scan(1'b1, 1, 1020, 1023, 2, -1, 0);

      full_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         r_sm = $urandom_range(0, 1); r_ch = $urandom_range(0, 7);
         r_st = $urandom_range(0, 1023); r_sp = r_st + $urandom_range(0, 10);
         if (r_sp > 1023) r_sp = 1023;
         r_stp = $urandom_range(0, 5);
         run_scan(r_sm[0], r_ch, r_st, r_sp, r_stp, -1, 0);
      end
      full_rand = 1'b0;

      clr_seq++;
      repeat (2) @(negedge Clk);
      wpp = 1; Single_or_Multi = 1'b1; Single_Chn = 3'd1;
      Dac_Start = 10'd0; Dac_Stop = 10'd40; Dac_Step = 10'd1;
      Test_Start = 1'b1;
      n0 = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge Clk);
         if (got.size() >= 5) begin n0 = 1; break; end
      end
      chk("midscan_point_reached", n0, 1);
      reset = 1'b1;
      @(negedge Clk);
      chk("midrst_busy", Test_Busy, 0);
      chk("midrst_wr_en", usb_data_fifo_wr_en, 0);
      chk("midrst_dac", Dac_Out, 0);
      chk("midrst_done", SCurve_Test_Done, 0);
      Test_Start = 1'b0;
      reset = 1'b0;
      repeat (20) @(negedge Clk);
      chk("midrst_stays_idle", Test_Busy, 0);
      chk("midrst_no_trailer", (got.size() > 0) && (got[got.size()-1] == 16'hFF45), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
